// File: rtl/seg_sched_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan scheduler.
// Owner encoding doubles as the one-hot gnt value.
package seg_sched_pkg;

  typedef logic [3:0][7:0] frame_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_0    = 2'b01,
    OWN_1    = 2'b10
  } owner_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx, input logic active_low);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return active_low ? ~oh : oh;
  endfunction

  function automatic logic [3:0] dig_off(input logic active_low);
    return active_low ? 4'b1111 : 4'b0000;
  endfunction

endpackage

// File: rtl/seg_arb.sv
// Frame-boundary arbiter: decides the display owner only at fb and enforces
// a minimum hold of HOLD_FRAMES frames before round-robin hand-over.
module seg_arb
  import seg_sched_pkg::*;
#(
  parameter int HOLD_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fb,
  output logic [1:0] owner,
  output logic [1:0] owner_next
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  owner_t        owner_q;
  owner_t        owner_d;
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          hold_expired;

  assign hold_expired = (hold_cnt_q == HW'(HOLD_FRAMES - 1));

  always_comb begin
    owner_d = owner_q;
    if (fb) begin
      case (owner_q)
        OWN_0: begin
          // A released owner re-arbitrates at once; the remaining source wins.
          if (!req[0])                     owner_d = req[1] ? OWN_1 : OWN_NONE;
          else if (req[1] && hold_expired) owner_d = OWN_1;
        end
        OWN_1: begin
          if (!req[1])                     owner_d = req[0] ? OWN_0 : OWN_NONE;
          else if (req[0] && hold_expired) owner_d = OWN_0;
        end
        default: begin
          if (req[0])      owner_d = OWN_0;
          else if (req[1]) owner_d = OWN_1;
          else             owner_d = OWN_NONE;
        end
      endcase
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (owner_d != owner_q)
      hold_cnt_d = '0;
    else if (fb && !hold_expired)
      hold_cnt_d = hold_cnt_q + HW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign owner      = owner_q;
  assign owner_next = owner_d;

endmodule

// File: rtl/seg_scan_sched.sv
// Display scan scheduler: digit scan counters, frame snapshot and registered
// segment/digit drive, with ownership decided by seg_arb at frame boundaries.
module seg_scan_sched
  import seg_sched_pkg::*;
#(
  parameter int DWELL          = 50_000,
  parameter int BLANK          = 1_000,
  parameter int HOLD_FRAMES    = 64,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [3:0][7:0] frame0,
  input  logic [3:0][7:0] frame1,
  output logic [1:0]      gnt,
  output logic [7:0]      seg,
  output logic [3:0]      dig,
  output logic            frame_done
);

  localparam int   CW      = $clog2(DWELL);
  localparam logic ACT_LOW = (DIG_ACTIVE_LOW != 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  frame_t        shadow_q, shadow_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;
  logic          frame_done_q, frame_done_d;

  logic          cnt_last;
  logic          fb;
  logic [1:0]    owner;
  logic [1:0]    owner_next;

  assign cnt_last = (cnt_q == CW'(DWELL - 1));
  assign fb       = cnt_last && (idx_q == 2'd3);

  seg_arb #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .fb        (fb),
    .owner     (owner),
    .owner_next(owner_next)
  );

  always_comb begin
    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d = cnt_last ? idx_q + 2'd1 : idx_q;
  end

  // Sources are only ever sampled here, so mid-frame edits never tear a frame.
  always_comb begin
    shadow_d = shadow_q;
    if (fb) begin
      case (owner_next)
        OWN_0:   shadow_d = frame0;
        OWN_1:   shadow_d = frame1;
        default: shadow_d = '0;
      endcase
    end
  end

  always_comb begin
    seg_d        = 8'h00;
    dig_d        = dig_off(ACT_LOW);
    frame_done_d = fb;
    if ((owner != OWN_NONE) && (cnt_q >= CW'(BLANK))) begin
      seg_d = shadow_q[idx_q];
      dig_d = onehot4(idx_q, ACT_LOW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      seg_q        <= 8'h00;
      dig_q        <= dig_off(ACT_LOW);
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gnt        = owner;
  assign seg        = seg_q;
  assign dig        = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed scoreboard bench for seg_scan_sched with DWELL=8, BLANK=2, HOLD_FRAMES=2.
// Each frame's expected pin sequence is queued up front and popped one cycle at a time.
module tb_seg_scan_sched;
  import seg_sched_pkg::*;

  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DWELL;

  logic            clk;
  logic            rst;
  logic [1:0]      req;
  logic [3:0][7:0] frame0;
  logic [3:0][7:0] frame1;
  logic [1:0]      gnt;
  logic [7:0]      seg;
  logic [3:0]      dig;
  logic            frame_done;

  typedef struct {
    logic [7:0] seg;
    logic [3:0] dig;
    logic [1:0] gnt;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  seg_scan_sched #(
    .DWELL(DWELL), .BLANK(BLANK), .HOLD_FRAMES(2), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .frame0(frame0), .frame1(frame1),
    .gnt(gnt), .seg(seg), .dig(dig), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Enter with the bench at a negedge right after a frame boundary edge.
  task automatic run_frame(input string tag, input logic [1:0] g_cur, input logic [1:0] g_next,
                           input frame_t pat, input int n_cyc, input int chg_at,
                           input logic [1:0] new_req, input frame_t new_f0, input frame_t new_f1);
    exp_t e;
    exp_t got;
    int   slot;
    int   c;
    logic [3:0] oh;
    for (int j = 0; j < FRAME; j++) begin
      slot = j / DWELL;
      c    = j % DWELL;
      oh   = 4'b0001 << slot;
      if (g_cur == 2'b00 || c < BLANK) begin
        e.seg = 8'h00;
        e.dig = 4'b1111;
      end else begin
        e.seg = pat[slot];
        e.dig = ~oh;
      end
      e.gnt = (j == FRAME - 1) ? g_next : g_cur;
      e.fd  = (j == FRAME - 1);
      exp_q.push_back(e);
    end
    for (int j = 0; j < n_cyc; j++) begin
      @(posedge clk);
      @(negedge clk);
      got = exp_q.pop_front();
      chk({tag, ".seg"}, seg, got.seg);
      chk({tag, ".dig"}, {4'h0, dig}, {4'h0, got.dig});
      chk({tag, ".gnt"}, {6'h0, gnt}, {6'h0, got.gnt});
      chk({tag, ".fd"},  {7'h0, frame_done}, {7'h0, got.fd});
      if (j == chg_at) begin
        req    = new_req;
        frame0 = new_f0;
        frame1 = new_f1;
      end
    end
    exp_q.delete();
    $display("frame %s gnt %b->%b cycles=%0d checks=%0d failures=%0d",
             tag, g_cur, g_next, n_cyc, checks, failures);
  endtask

  task automatic do_reset(input string tag, input logic [1:0] r, input frame_t f0, input frame_t f1);
    rst    = 1'b1;
    req    = r;
    frame0 = f0;
    frame1 = f1;
    repeat (2) @(negedge clk);
    chk({tag, ".rst_seg"}, seg, 8'h00);
    chk({tag, ".rst_dig"}, {4'h0, dig}, 8'h0F);
    chk({tag, ".rst_gnt"}, {6'h0, gnt}, 8'h00);
    chk({tag, ".rst_fd"},  {7'h0, frame_done}, 8'h00);
    rst = 1'b0;
    $display("reset %s req=%b", tag, r);
  endtask

  frame_t p_a, p_a2, p_b, p_z;

  initial begin
    rst    = 1'b1;
    req    = 2'b00;
    p_a    = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    p_a2   = p_a;
    p_a2[1] = 8'h7F;
    p_b    = {8'h66, 8'h6D, 8'h7D, 8'h07};
    p_z    = '0;
    frame0 = p_z;
    frame1 = p_z;

    // Idle: no requester, blank display, frame_done every 32 cycles.
    do_reset("idle", 2'b00, p_a, p_b);
    run_frame("idle0", 2'b00, 2'b00, p_z, FRAME, -1, 2'b00, p_a, p_b);
    run_frame("idle1", 2'b00, 2'b00, p_z, FRAME, -1, 2'b00, p_a, p_b);

    // Single source, plus a mid-frame edit of digit 1 held off until the next boundary.
    do_reset("src0", 2'b01, p_a, p_b);
    run_frame("src0_acq", 2'b00, 2'b01, p_z, FRAME, -1, 2'b01, p_a, p_b);
    run_frame("src0_edit", 2'b01, 2'b01, p_a, FRAME, 12, 2'b01, p_a2, p_b);
    run_frame("src0_new", 2'b01, 2'b01, p_a2, FRAME, -1, 2'b01, p_a2, p_b);

    // Both requesting: two-frame hold then round-robin.
    do_reset("rr", 2'b11, p_a, p_b);
    run_frame("rr_acq", 2'b00, 2'b01, p_z, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("rr_o0a", 2'b01, 2'b01, p_a, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("rr_o0b", 2'b01, 2'b10, p_a, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("rr_o1a", 2'b10, 2'b10, p_b, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("rr_o1b", 2'b10, 2'b01, p_b, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("rr_o0c", 2'b01, 2'b01, p_a, FRAME, -1, 2'b11, p_a, p_b);

    // Owner 0 drops mid-frame before hold expiry: grant moves only at the boundary.
    do_reset("drop", 2'b11, p_a, p_b);
    run_frame("drop_acq", 2'b00, 2'b01, p_z, FRAME, -1, 2'b11, p_a, p_b);
    run_frame("drop_mid", 2'b01, 2'b10, p_a, FRAME, 10, 2'b10, p_a, p_b);
    run_frame("drop_o1", 2'b10, 2'b10, p_b, FRAME, -1, 2'b10, p_a, p_b);

    // Asynchronous reset in the ON phase of digit 2.
    do_reset("arst", 2'b01, p_a, p_b);
    run_frame("arst_acq", 2'b00, 2'b01, p_z, FRAME, -1, 2'b01, p_a, p_b);
    run_frame("arst_pre", 2'b01, 2'b01, p_a, 21, -1, 2'b01, p_a, p_b);
    chk("arst.pre_seg", seg, 8'h5B);
    #2 rst = 1'b1;
    #1;
    chk("arst.async_seg", seg, 8'h00);
    chk("arst.async_dig", {4'h0, dig}, 8'h0F);
    chk("arst.async_gnt", {6'h0, gnt}, 8'h00);
    $display("async reset asserted mid digit 2");
    @(negedge clk);
    rst = 1'b0;
    run_frame("arst_re", 2'b00, 2'b01, p_z, FRAME, -1, 2'b01, p_a, p_b);
    run_frame("arst_run", 2'b01, 2'b01, p_a, FRAME, -1, 2'b01, p_a, p_b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
